// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline from ID through EX, MEM and WB: destination resolution,
// stall/flush bubbles, EX-stage forwarding selects and a retired-instruction counter.
module ctrl_pipe #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic             RegDst_i,
  input  logic [2:0]       ALUOp_i,
  input  logic             ALUSrc_i,
  input  logic             RegWrite_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic [REG_W-1:0] rd_i,
  output logic             ex_valid_o,
  output logic [2:0]       ex_ALUOp_o,
  output logic             ex_ALUSrc_o,
  output logic [1:0]       ex_fwdA_o,
  output logic [1:0]       ex_fwdB_o,
  output logic             mem_valid_o,
  output logic             mem_RegWrite_o,
  output logic [REG_W-1:0] mem_rd_o,
  output logic             wb_RegWrite_o,
  output logic [REG_W-1:0] wb_rd_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  logic             id_vld, id_alusrc, id_regwr;
  logic [2:0]       id_aluop;
  logic [REG_W-1:0] id_dest, id_rs, id_rt;

  logic             vld_p0, alusrc_p0, regwr_p0;
  logic [2:0]       aluop_p0;
  logic [REG_W-1:0] dest_p0, rs_p0, rt_p0;
  logic             vld_p1, regwr_p1;
  logic [REG_W-1:0] dest_p1;
  logic             vld_p2, regwr_p2;
  logic [REG_W-1:0] dest_p2;
  logic [CNT_W-1:0] retire_cnt;

  // MEM result wins over WB result; register 0 and bubbles never forward.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
    if (vld_p1 && regwr_p1 && (dest_p1 != '0) && (dest_p1 == src))
      return 2'b10;
    else if (vld_p2 && regwr_p2 && (dest_p2 != '0) && (dest_p2 == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    id_vld    = id_valid_i;
    id_aluop  = id_valid_i ? ALUOp_i    : 3'b000;
    id_alusrc = id_valid_i ? ALUSrc_i   : 1'b0;
    id_regwr  = id_valid_i ? RegWrite_i : 1'b0;
    id_dest   = id_valid_i ? (RegDst_i ? rd_i : rt_i) : '0;
    id_rs     = id_valid_i ? rs_i : '0;
    id_rt     = id_valid_i ? rt_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p0     <= 1'b0;
      aluop_p0   <= 3'b000;
      alusrc_p0  <= 1'b0;
      regwr_p0   <= 1'b0;
      dest_p0    <= '0;
      rs_p0      <= '0;
      rt_p0      <= '0;
      vld_p1     <= 1'b0;
      regwr_p1   <= 1'b0;
      dest_p1    <= '0;
      vld_p2     <= 1'b0;
      regwr_p2   <= 1'b0;
      dest_p2    <= '0;
      retire_cnt <= '0;
    end else begin
      // ID -> EX: flush beats stall; stall holds EX
      if (flush_i) begin
        vld_p0    <= 1'b0;
        aluop_p0  <= 3'b000;
        alusrc_p0 <= 1'b0;
        regwr_p0  <= 1'b0;
        dest_p0   <= '0;
        rs_p0     <= '0;
        rt_p0     <= '0;
      end else if (!stall_i) begin
        vld_p0    <= id_vld;
        aluop_p0  <= id_aluop;
        alusrc_p0 <= id_alusrc;
        regwr_p0  <= id_regwr;
        dest_p0   <= id_dest;
        rs_p0     <= id_rs;
        rt_p0     <= id_rt;
      end
      // EX -> MEM: a plain stall leaves a bubble behind the held instruction
      if (flush_i || !stall_i) begin
        vld_p1   <= vld_p0;
        regwr_p1 <= regwr_p0;
        dest_p1  <= dest_p0;
      end else begin
        vld_p1   <= 1'b0;
        regwr_p1 <= 1'b0;
        dest_p1  <= '0;
      end
      // MEM -> WB
      vld_p2   <= vld_p1;
      regwr_p2 <= regwr_p1;
      dest_p2  <= dest_p1;
      // WB -> retire
      if (vld_p2)
        retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  assign ex_valid_o     = vld_p0;
  assign ex_ALUOp_o     = aluop_p0;
  assign ex_ALUSrc_o    = alusrc_p0;
  assign ex_fwdA_o      = vld_p0 ? fwd_sel(rs_p0) : 2'b00;
  assign ex_fwdB_o      = vld_p0 ? fwd_sel(rt_p0) : 2'b00;
  assign mem_valid_o    = vld_p1;
  assign mem_RegWrite_o = regwr_p1;
  assign mem_rd_o       = dest_p1;
  assign wb_RegWrite_o  = vld_p2 & regwr_p2;
  assign wb_rd_o        = dest_p2;
  assign retire_cnt_o   = retire_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe with a 4-bit retire counter so wrap-around is reachable.
module tb_ctrl_pipe;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_n_i, stall_i, flush_i, id_valid_i;
  logic             RegDst_i, ALUSrc_i, RegWrite_i;
  logic [2:0]       ALUOp_i;
  logic [REG_W-1:0] rs_i, rt_i, rd_i;
  logic             ex_valid_o, ex_ALUSrc_o, mem_valid_o, mem_RegWrite_o, wb_RegWrite_o;
  logic [2:0]       ex_ALUOp_o;
  logic [1:0]       ex_fwdA_o, ex_fwdB_o;
  logic [REG_W-1:0] mem_rd_o, wb_rd_o;
  logic [CNT_W-1:0] retire_cnt_o;

  int checks = 0;
  int errors = 0;

  ctrl_pipe #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .RegDst_i(RegDst_i), .ALUOp_i(ALUOp_i),
    .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i),
    .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
    .ex_valid_o(ex_valid_o), .ex_ALUOp_o(ex_ALUOp_o), .ex_ALUSrc_o(ex_ALUSrc_o),
    .ex_fwdA_o(ex_fwdA_o), .ex_fwdB_o(ex_fwdB_o),
    .mem_valid_o(mem_valid_o), .mem_RegWrite_o(mem_RegWrite_o), .mem_rd_o(mem_rd_o),
    .wb_RegWrite_o(wb_RegWrite_o), .wb_rd_o(wb_rd_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_id(input logic v, input logic rdst, input logic [2:0] op,
                        input logic asrc, input logic rw, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd);
    id_valid_i = v; RegDst_i = rdst; ALUOp_i = op; ALUSrc_i = asrc;
    RegWrite_i = rw; rs_i = rs; rt_i = rt; rd_i = rd;
  endtask

  task automatic idle();
    set_id(1'b0, 1'b1, 3'b111, 1'b1, 1'b1, 5'd31, 5'd30, 5'd29);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {ex_valid_o, ex_ALUOp_o, ex_ALUSrc_o, ex_fwdA_o, ex_fwdB_o,
                           mem_valid_o, mem_RegWrite_o, mem_rd_o, wb_RegWrite_o, wb_rd_o},
          32'd0);
    check({tag, "_cnt"}, retire_cnt_o, 32'd0);
  endtask

  initial begin
    rst_n_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    idle();
    #1 rst_n_i = 1'b0;
    #1 check_all_zero("reset");
    tick(); tick();
    check_all_zero("reset_held");
    rst_n_i = 1'b1;

    // R-type fill: dest=rd=5
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 5'd1, 5'd3, 5'd5);
    tick();
    check("r_ex_valid", ex_valid_o, 1);
    check("r_ex_aluop", ex_ALUOp_o, 3'b111);
    check("r_ex_alusrc", ex_ALUSrc_o, 0);
    idle();
    tick();
    check("r_mem_rd", mem_rd_o, 5);
    check("r_mem_rw", mem_RegWrite_o, 1);
    check("r_ex_bubble", ex_valid_o, 0);
    tick();
    check("r_wb_rd", wb_rd_o, 5);
    check("r_wb_rw", wb_RegWrite_o, 1);
    check("r_cnt_before", retire_cnt_o, 0);
    tick();
    check("r_retire", retire_cnt_o, 1);
    check("r_wb_drained", wb_RegWrite_o, 0);

    // I-type: dest=rt=7
    set_id(1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 5'd2, 5'd7, 5'd9);
    tick();
    check("i_ex_alusrc", ex_ALUSrc_o, 1);
    check("i_ex_aluop", ex_ALUOp_o, 3'b000);
    idle();
    tick();
    check("i_mem_rd", mem_rd_o, 7);
    tick(); tick();
    check("i_retire", retire_cnt_o, 2);

    // Two writers of r4 then reader of r4: MEM has priority
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 5'd1, 5'd2, 5'd4);
    tick();
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 5'd1, 5'd2, 5'd4);
    tick();
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 5'd4, 5'd4, 5'd0);
    tick();
    check("fwd_prio_a", ex_fwdA_o, 2'b10);
    check("fwd_prio_b", ex_fwdB_o, 2'b10);
    // writer, bubble, reader: WB forward
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 5'd1, 5'd2, 5'd4);
    tick();
    idle();
    tick();
    check("fwd_bubble_ex", {ex_fwdA_o, ex_fwdB_o}, 4'b0000);
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 5'd4, 5'd4, 5'd0);
    tick();
    check("fwd_wb_a", ex_fwdA_o, 2'b01);
    check("fwd_wb_b", ex_fwdB_o, 2'b01);
    // writer to r0 never forwards
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    check("fwd_r0", {ex_fwdA_o, ex_fwdB_o}, 4'b0000);
    // writers r4 then r6; reader rs=6 (MEM), rt=4 (WB)
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 5'd1, 5'd2, 5'd4);
    tick();
    set_id(1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 5'd1, 5'd6, 5'd0);
    tick();
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 5'd6, 5'd4, 5'd0);
    tick();
    check("fwd_mix_a", ex_fwdA_o, 2'b10);
    check("fwd_mix_b", ex_fwdB_o, 2'b01);
    idle();
    tick(); tick(); tick();
    check("fwd_retire", retire_cnt_o, 12);

    // Stall two cycles with X (rd=8) in EX
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 5'd1, 5'd2, 5'd8);
    tick();
    idle();
    stall_i = 1'b1;
    tick();
    check("stall1_ex", ex_valid_o, 1);
    check("stall1_mem", mem_valid_o, 0);
    tick();
    check("stall2_ex", ex_valid_o, 1);
    check("stall2_mem", mem_valid_o, 0);
    stall_i = 1'b0;
    tick();
    check("stall_mem_x", {mem_valid_o, mem_rd_o}, {1'b1, 5'd8});
    check("stall_ex_empty", ex_valid_o, 0);
    tick();
    check("stall_wb_x", wb_rd_o, 8);
    check("stall_cnt_before", retire_cnt_o, 12);
    tick();
    check("stall_retire", retire_cnt_o, 13);

    // Flush with stall: X2 (rd=10) advances, EX gets a bubble, Z discarded
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 5'd1, 5'd2, 5'd10);
    tick();
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 5'd1, 5'd2, 5'd15);
    stall_i = 1'b1; flush_i = 1'b1;
    tick();
    stall_i = 1'b0; flush_i = 1'b0;
    check("flush_ex", ex_valid_o, 0);
    check("flush_mem", {mem_valid_o, mem_rd_o}, {1'b1, 5'd10});

    // Three in flight, then asynchronous reset between edges
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 5'd1, 5'd2, 5'd11);
    tick();
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 5'd1, 5'd2, 5'd12);
    tick();
    set_id(1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 5'd1, 5'd2, 5'd13);
    tick();
    check("inflight_wb", wb_rd_o, 11);
    check("inflight_cnt", retire_cnt_o, 14);
    idle();
    #2 rst_n_i = 1'b0;
    #1 check_all_zero("async_rst");
    #1 rst_n_i = 1'b1;
    tick(); tick(); tick(); tick();
    check("post_rst_cnt", retire_cnt_o, 0);
    check("post_rst_wb", wb_RegWrite_o, 0);

    // 17 retirements on a 4-bit counter wrap to 1
    for (int i = 0; i < 17; i++) begin
      set_id(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 5'd0, 5'd1, 5'd0);
      tick();
    end
    idle();
    tick(); tick();
    check("wrap_pre", retire_cnt_o, 0);
    tick();
    check("wrap_cnt", retire_cnt_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the main decoder's control bundle (RegDst, ALUOp[2:0], ALUSrc, RegWrite).
- Carries each decoded instruction's control through the EX, MEM and WB pipeline registers.
- Resolves the destination register (RegDst mux) in the ID->EX transfer and generates EX-stage forwarding selects from the MEM and WB writers.
- Handles stall and flush bubbles and counts retired instructions; sits between ID and the EX datapath / register-file write port.

Parameters:
- REG_W, 5, register index width.
- CNT_W, 32, retire counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- stall_i  in  1  hold the EX stage; inject a bubble into MEM.
- flush_i  in  1  replace the instruction entering EX with a bubble.
- id_valid_i  in  1  ID holds a real instruction.
- RegDst_i  in  1  1: dest=rd, 0: dest=rt.
- ALUOp_i  in  3  ALU operation code (3'b111 R-type, 3'b000 add).
- ALUSrc_i  in  1  1: immediate operand.
- RegWrite_i  in  1  instruction writes the register file.
- rs_i, rt_i, rd_i  in  REG_W each  instruction register fields.
- ex_valid_o  out  1  EX holds a real instruction.
- ex_ALUOp_o  out  3  ALUOp of the EX instruction.
- ex_ALUSrc_o  out  1  ALUSrc of the EX instruction.
- ex_fwdA_o, ex_fwdB_o  out  2 each  operand source: 00 regfile, 10 MEM result, 01 WB result.
- mem_valid_o  out  1  MEM holds a real instruction.
- mem_RegWrite_o  out  1  MEM-stage write enable.
- mem_rd_o  out  REG_W  MEM-stage destination.
- wb_RegWrite_o  out  1  register-file write enable.
- wb_rd_o  out  REG_W  register-file write address.
- retire_cnt_o  out  CNT_W  count of valid instructions that have left WB.

Behaviour:
Reset (rst_n_i=0, asynchronous):
- All stage registers go to bubble; every output is 0, including retire_cnt_o.
- Reset mid-operation discards all in-flight instructions immediately.

Bubble definition:
- valid=0, RegWrite=0, ALUOp=000, ALUSrc=0, dest=0, rs=rt=0.

ID->EX transfer:
- dest = RegDst_i ? rd_i : rt_i, resolved at transfer time.
- EX stores valid, ALUOp, ALUSrc, RegWrite, dest, rs, rt.
- If id_valid_i=0, a bubble enters EX regardless of the other inputs.

Per rising edge, in priority order:
- flush_i=1 (overrides stall_i): EX<=bubble, MEM<=EX, WB<=MEM.
- stall_i=1: EX holds, MEM<=bubble, WB<=MEM.
- otherwise: EX<=ID, MEM<=EX, WB<=MEM.

Retire counter:
- Increments when the WB register holds valid=1 at the clock edge (one instruction leaving WB).
- Wraps modulo 2^CNT_W with no saturation.
- Latency: an instruction accepted at edge N retires at edge N+3, so retire_cnt_o reflects it after edge N+3.

Forwarding (combinational on EX, MEM and WB registers; zero added latency):
- fwdA=10 if mem_valid & mem_RegWrite & mem_rd!=0 & mem_rd==ex_rs.
- Else fwdA=01 if wb_valid & wb_RegWrite & wb_rd!=0 & wb_rd==ex_rs.
- Else fwdA=00. fwdB is identical using ex_rt.
- MEM has priority over WB when both match.
- A destination of register 0 never forwards.
- Bubbles never forward; if ex_valid=0, both selects are 00.

Outputs:
- Registered stage state, except the fwd selects.
- wb_RegWrite_o is valid-gated, so it is never 1 for a bubble.

Test Plan:
- Reset and fill: release reset; ID=R-type (RegDst=1, ALUOp=111, rd=5, rt=3) valid for 1 cycle -> edge1: ex_ALUOp_o=111, ex_ALUSrc_o=0; edge2: mem_rd_o=5, mem_RegWrite_o=1; edge3: wb_rd_o=5, wb_RegWrite_o=1; edge4: retire_cnt_o=1.
- I-type dest: RegDst=0, ALUOp=000, ALUSrc=1, rt=7, rd=9 -> mem_rd_o=7 two edges later, ex_ALUSrc_o=1 after one edge.
- Forward priority: back-to-back writers to r4, then a reader with rs=4 and rt=4 -> reader in EX while both older writers are in MEM and WB gives fwdA=fwdB=10; with a bubble between writer and reader gives 01; writer dest r0 gives 00.
- Stall/flush: stall_i high for 2 cycles with instruction X in EX -> X held in EX, mem_valid_o=0 for 2 cycles, X retires 2 cycles late. Assert flush_i together with stall_i -> EX becomes a bubble, X advances to MEM.
- Async reset mid-stream: pull rst_n_i low between edges with 3 instructions in flight -> all outputs 0 without waiting for a clock edge, retire_cnt_o=0; after release with no valid input, the counter stays 0.
- Counter wrap: CNT_W=4, retire 17 instructions -> retire_cnt_o=1.
